// File: rtl/dram_fetch_pkg.sv
// dram_fetch_pkg
// Shared definitions for the DRAM burst fetcher:
//   - default parameter values for the fetcher and its credit counter
//   - fetch_state_e, the fetcher FSM state encoding
//   - min_len(), used to clip the remaining length to one burst
package dram_fetch_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_LEN_W       = 16;
    localparam int DEF_MAX_BURST   = 64;
    localparam int DEF_CREDIT_MAX  = 128;
    localparam int DEF_ACK_TIMEOUT = 256;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CREDIT,
        REQ,
        DATA
    } fetch_state_e;

    function automatic int unsigned min_len(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fetch_credit_counter.sv
// fetch_credit_counter
// Tracks free words in the downstream staging FIFO. Starts full at CREDIT_MAX.
// A reservation subtracts a whole burst up front so that returned beats always
// have somewhere to land; each credit_return adds one word back.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   reserve_i     take burst_i credits this cycle
//   burst_i       burst length in words (also the can_issue compare operand)
//   return_i      one word was popped downstream
//   credits_o     current credit count
//   can_issue_o   credits_o >= burst_i
//   overflow_o    return arrived with the counter already full (one-cycle pulse)
module fetch_credit_counter
    import dram_fetch_pkg::*;
#(
    parameter  int CREDIT_MAX = DEF_CREDIT_MAX,
    parameter  int LEN_W      = DEF_LEN_W,
    localparam int CW         = $clog2(CREDIT_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reserve_i,
    input  logic [LEN_W-1:0] burst_i,
    input  logic             return_i,
    output logic [CW-1:0]    credits_o,
    output logic             can_issue_o,
    output logic             overflow_o
);

    logic [CW-1:0] credits_q;
    logic [CW-1:0] credits_d;

    // A return in the same cycle as a reservation can never overflow, since
    // the burst being reserved is at least one word.
    always_comb begin
        credits_d  = credits_q;
        overflow_o = 1'b0;
        if (reserve_i) begin
            credits_d = credits_q - CW'(burst_i) + CW'(return_i);
        end else if (return_i) begin
            if (credits_q == CW'(CREDIT_MAX)) begin
                overflow_o = 1'b1;
            end else begin
                credits_d = credits_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q <= CW'(CREDIT_MAX);
        end else begin
            credits_q <= credits_d;
        end
    end

    assign credits_o   = credits_q;
    assign can_issue_o = (32'(credits_q) >= 32'(burst_i));

endmodule

// File: rtl/dram_burst_fetcher.sv
// dram_burst_fetcher
// Read-side DMA engine: splits a linear read command (byte address + word
// count) into DRAM bursts of at most MAX_BURST words, issues each burst only
// once the staging FIFO has room for all of it, and forwards returned beats
// one cycle later as FIFO push strobes.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_addr/cmd_len read command (cmd_len == 0 is a no-op)
//   dram_req/dram_addr/dram_len/dram_ack burst request handshake
//   dram_data_valid/dram_data_in        returned beats (no backpressure)
//   out_valid/out_data                  staging FIFO push
//   credit_return                       one word popped from the staging FIFO
//   busy                                not IDLE
//   done                                one-cycle pulse on command completion
//   error                               sticky: stray beat, credit overflow,
//                                       or ack watchdog expiry
//
// Build option: define DRAM_FETCH_TIMEOUT_EN to enable the REQ watchdog,
// which aborts to IDLE with error set after ACK_TIMEOUT cycles without ack.
module dram_burst_fetcher
    import dram_fetch_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int MAX_BURST   = DEF_MAX_BURST,
    parameter int CREDIT_MAX  = DEF_CREDIT_MAX,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              dram_req,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [LEN_W-1:0]  dram_len,
    input  logic              dram_ack,
    input  logic              dram_data_valid,
    input  logic [DATA_W-1:0] dram_data_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              credit_return,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CW    = $clog2(CREDIT_MAX + 1);
    localparam int BYTES = DATA_W / 8;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic              dram_req_q;
    logic [ADDR_W-1:0] dram_addr_q;
    logic [LEN_W-1:0]  dram_len_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              done_q;
    logic              done_pend_q;
    logic              error_q;
`ifdef DRAM_FETCH_TIMEOUT_EN
    localparam int WD_W = $clog2(ACK_TIMEOUT + 1);
    logic [WD_W-1:0]   wd_cnt_q;
`endif

    logic [LEN_W-1:0]  burst;
    logic              reserve;
    logic              can_issue;
    logic              credit_overflow;
    logic [CW-1:0]     credits;
    logic              last_beat;

    assign burst     = LEN_W'(min_len(32'(remaining_q), 32'(MAX_BURST)));
    assign reserve   = (state_q == WAIT_CREDIT) && can_issue;
    assign last_beat = (state_q == DATA) && dram_data_valid &&
                       ((beat_cnt_q + LEN_W'(1)) == dram_len_q);

    fetch_credit_counter #(
        .CREDIT_MAX (CREDIT_MAX),
        .LEN_W      (LEN_W)
    ) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .reserve_i   (reserve),
        .burst_i     (burst),
        .return_i    (credit_return),
        .credits_o   (credits),
        .can_issue_o (can_issue),
        .overflow_o  (credit_overflow)
    );

    // Main sequencer. done is delayed through done_pend_q so that it lands in
    // the cycle after the final beat's out_valid rather than alongside it.
    // A watchdog abort does not refund the credits reserved for that burst,
    // because the DRAM may still return its beats later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            dram_req_q  <= 1'b0;
            dram_addr_q <= '0;
            dram_len_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            done_pend_q <= 1'b0;
            error_q     <= 1'b0;
`ifdef DRAM_FETCH_TIMEOUT_EN
            wd_cnt_q    <= '0;
`endif
        end else begin
            done_q      <= done_pend_q;
            done_pend_q <= 1'b0;
            out_valid_q <= 1'b0;

            if (credit_overflow || (dram_data_valid && (state_q != DATA))) begin
                error_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_addr;
                        remaining_q <= cmd_len;
                        if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= WAIT_CREDIT;
                        end
                    end
                end

                WAIT_CREDIT: begin
                    if (can_issue) begin
                        dram_req_q  <= 1'b1;
                        dram_addr_q <= addr_q;
                        dram_len_q  <= burst;
                        beat_cnt_q  <= '0;
`ifdef DRAM_FETCH_TIMEOUT_EN
                        wd_cnt_q    <= '0;
`endif
                        state_q     <= REQ;
                    end
                end

                REQ: begin
                    if (dram_ack) begin
                        dram_req_q <= 1'b0;
                        state_q    <= DATA;
                    end
`ifdef DRAM_FETCH_TIMEOUT_EN
                    else if (wd_cnt_q == WD_W'(ACK_TIMEOUT - 1)) begin
                        dram_req_q <= 1'b0;
                        error_q    <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
`endif
                end

                DATA: begin
                    if (dram_data_valid) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= dram_data_in;
                        beat_cnt_q  <= beat_cnt_q + LEN_W'(1);
                    end
                    if (last_beat) begin
                        remaining_q <= remaining_q - dram_len_q;
                        addr_q      <= addr_q + (ADDR_W'(dram_len_q) * ADDR_W'(BYTES));
                        if (remaining_q == dram_len_q) begin
                            done_pend_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= WAIT_CREDIT;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign dram_req  = dram_req_q;
    assign dram_addr = dram_addr_q;
    assign dram_len  = dram_len_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_dram_burst_fetcher.sv
// tb_dram_burst_fetcher
// Directed bench for dram_burst_fetcher with default parameters
// (DATA_W=16, MAX_BURST=64, CREDIT_MAX=128, ACK_TIMEOUT=256).
// Inputs are driven and outputs sampled on the falling clock edge.
// The watchdog scenario is compiled only when DRAM_FETCH_TIMEOUT_EN is defined.
module tb_dram_burst_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        dram_req;
    logic [31:0] dram_addr;
    logic [15:0] dram_len;
    logic        dram_ack = 1'b0;
    logic        dram_data_valid = 1'b0;
    logic [15:0] dram_data_in = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        credit_return = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    dram_burst_fetcher dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .dram_req        (dram_req),
        .dram_addr       (dram_addr),
        .dram_len        (dram_len),
        .dram_ack        (dram_ack),
        .dram_data_valid (dram_data_valid),
        .dram_data_in    (dram_data_in),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .credit_return   (credit_return),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one command for a single edge; returns on the falling edge
    // right after the accepting rising edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] len);
        checkOutput("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Plays the DRAM side of one burst: waits for the request, checks it,
    // acks, then returns nBeats back-to-back beats and checks each push.
    task automatic serveBurst(input logic [31:0] expAddr, input int expLen,
                              input logic [15:0] dataBase, input int nBeats);
        int waited = 0;
        logic [15:0] beat;
        while (!dram_req && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("dram_req_seen", 64'(dram_req), 64'd1);
        checkOutput("dram_addr", 64'(dram_addr), 64'(expAddr));
        checkOutput("dram_len", 64'(dram_len), 64'(expLen));
        dram_ack = 1'b1;
        @(negedge clk);
        dram_ack = 1'b0;
        checkOutput("dram_req_dropped", 64'(dram_req), 64'd0);
        checkOutput("out_valid_before_beats", 64'(out_valid), 64'd0);
        for (int i = 0; i < nBeats; i++) begin
            beat            = dataBase + 16'(i);
            dram_data_valid = 1'b1;
            dram_data_in    = beat;
            @(negedge clk);
            checkOutput("beat_out_valid", 64'(out_valid), 64'd1);
            checkOutput("beat_out_data", 64'(out_data), 64'(beat));
            checkOutput("beat_no_early_done", 64'(done), 64'd0);
        end
        dram_data_valid = 1'b0;
    endtask

    // Expects the done pulse one cycle after the final push, lasting one cycle.
    task automatic checkDone();
        @(negedge clk);
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("out_valid_after_last", 64'(out_valid), 64'd0);
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_dram_req", 64'(dram_req), 64'd0);
        checkOutput("rst_dram_addr", 64'(dram_addr), 64'd0);
        checkOutput("rst_dram_len", 64'(dram_len), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_error", 64'(error), 64'd0);
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("rst_credits", 64'(dut.credits), 64'd128);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed no end of test, expected $finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        checkResetValues();
        rst_n = 1'b1;
        @(negedge clk);

        // 100 words at 0x1000: bursts of 64 then 36, 2 bytes per word
        $display("[TB] two-burst command");
        applyStimulus(32'h0000_1000, 16'd100);
        checkOutput("busy_wait_credit", 64'(busy), 64'd1);
        checkOutput("no_req_yet", 64'(dram_req), 64'd0);
        serveBurst(32'h0000_1000, 64, 16'h0100, 64);
        serveBurst(32'h0000_1080, 36, 16'h0200, 36);
        checkDone();
        checkOutput("credits_after_100", 64'(dut.credits), 64'd28);
        checkOutput("no_error_t1", 64'(error), 64'd0);

        // 64 words with only 28 credits: stalls until 36 come back.
        // The return on the reserving edge nets to 64 - 64 + 1 = 1.
        $display("[TB] credit stall");
        applyStimulus(32'h0000_2000, 16'd64);
        repeat (5) @(negedge clk);
        checkOutput("stall_no_req", 64'(dram_req), 64'd0);
        checkOutput("stall_busy", 64'(busy), 64'd1);
        checkOutput("stall_credits", 64'(dut.credits), 64'd28);
        credit_return = 1'b1;
        repeat (35) @(negedge clk);
        checkOutput("credits_63", 64'(dut.credits), 64'd63);
        checkOutput("no_req_at_63", 64'(dram_req), 64'd0);
        @(negedge clk);
        checkOutput("credits_64", 64'(dut.credits), 64'd64);
        checkOutput("no_req_at_64", 64'(dram_req), 64'd0);
        @(negedge clk);
        credit_return = 1'b0;
        checkOutput("req_after_credits", 64'(dram_req), 64'd1);
        checkOutput("reserve_plus_return", 64'(dut.credits), 64'd1);
        serveBurst(32'h0000_2000, 64, 16'h0300, 64);
        checkDone();
        checkOutput("credits_after_64", 64'(dut.credits), 64'd1);

        // Zero-length command
        $display("[TB] zero-length command");
        applyStimulus(32'h0000_4000, 16'd0);
        checkOutput("len0_done", 64'(done), 64'd1);
        checkOutput("len0_busy", 64'(busy), 64'd0);
        checkOutput("len0_no_req", 64'(dram_req), 64'd0);
        @(negedge clk);
        checkOutput("len0_done_cleared", 64'(done), 64'd0);
        checkOutput("len0_busy_after", 64'(busy), 64'd0);
        checkOutput("len0_no_req_after", 64'(dram_req), 64'd0);

        // Refill to 128, then one extra return saturates and flags error
        $display("[TB] credit overflow");
        credit_return = 1'b1;
        repeat (127) @(negedge clk);
        checkOutput("credits_full", 64'(dut.credits), 64'd128);
        checkOutput("no_error_at_full", 64'(error), 64'd0);
        @(negedge clk);
        credit_return = 1'b0;
        checkOutput("credits_saturated", 64'(dut.credits), 64'd128);
        checkOutput("overflow_error", 64'(error), 64'd1);

        // Reset mid-burst after 10 beats, then a fresh 4-word command
        $display("[TB] reset mid-burst");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("error_cleared_by_reset", 64'(error), 64'd0);
        applyStimulus(32'h0000_5000, 16'd20);
        serveBurst(32'h0000_5000, 20, 16'h0400, 10);
        checkOutput("mid_burst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkResetValues();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(32'h0000_6000, 16'd4);
        serveBurst(32'h0000_6000, 4, 16'h0500, 4);
        checkDone();
        checkOutput("credits_after_4", 64'(dut.credits), 64'd124);

        // Stray beat in IDLE is dropped and flags a sticky error
        $display("[TB] stray beat");
        dram_data_valid = 1'b1;
        dram_data_in    = 16'hDEAD;
        @(negedge clk);
        dram_data_valid = 1'b0;
        checkOutput("stray_error", 64'(error), 64'd1);
        checkOutput("stray_dropped", 64'(out_valid), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("stray_error_sticky", 64'(error), 64'd1);
        checkOutput("stray_still_dropped", 64'(out_valid), 64'd0);

`ifdef DRAM_FETCH_TIMEOUT_EN
        // Withheld ack: abort after 256 cycles in REQ, no done pulse
        begin
            int n = 0;
            int waited = 0;
            logic sawDone = 1'b0;
            $display("[TB] ack watchdog");
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            applyStimulus(32'h0000_7000, 16'd4);
            while (!dram_req && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("wd_req_seen", 64'(dram_req), 64'd1);
            while (busy && n < 400) begin
                @(negedge clk);
                n++;
                if (done) sawDone = 1'b1;
            end
            checkOutput("wd_cycles_in_req", 64'(n), 64'd256);
            checkOutput("wd_error", 64'(error), 64'd1);
            checkOutput("wd_no_done", 64'(sawDone), 64'd0);
            checkOutput("wd_req_dropped", 64'(dram_req), 64'd0);
            checkOutput("wd_back_to_idle", 64'(cmd_ready), 64'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
